fc_layer_seq: RTL and testbench
===============================

FC_LAYER_SEQ -- requirements
Module: fc_layer_seq

Interface
REQ-001 Parameter IN_SIZE, 784, input vector length (>=2).
REQ-002 Parameter NUM_NEURONS, 16, output neurons (>=1).
REQ-003 Parameter LANES, 4, parallel MAC lanes; NUM_NEURONS SHALL be a multiple of LANES.
REQ-004 Parameter DATA_W, 16, signed fixed-point width of activations, weights, biases and outputs.
REQ-005 Parameter FRAC_BITS, 8, fractional bits of every DATA_W value.
REQ-006 Derived ACC_W = 2*DATA_W + clog2(IN_SIZE) + 1, signed accumulator width; no accumulator overflow is possible.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 in_valid / in_ready / in_data[DATA_W] / in_last  in/out/in/in  activation stream, one element per accepted beat.
REQ-010 relu_en  in  1  activation mode, sampled on the first accepted input beat of a vector.
REQ-011 w_rd  out  1, w_addr  out  clog2(NUM_NEURONS/LANES*IN_SIZE), w_data  in  LANES*DATA_W  weight memory port; w_addr = group*IN_SIZE + i, lane l in w_data bits [l*DATA_W +: DATA_W], data valid exactly one cycle after w_rd.
REQ-012 b_rd  out  1, b_addr  out  clog2(NUM_NEURONS/LANES), b_data  in  LANES*DATA_W  bias port, same one-cycle read latency and lane packing.
REQ-013 out_valid / out_ready / out_data[DATA_W] / out_idx[clog2(NUM_NEURONS)] / out_last  out/in/out/out/out  result stream.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 err_len  out  1  one-cycle pulse on input length mismatch.

Function
REQ-016 States: IDLE, LOAD, MAC, WB, OUT.
REQ-017 IDLE/LOAD: in_ready=1; each accepted beat writes in_data into input buffer[cnt]; the beat with cnt=IN_SIZE-1 moves to MAC; in_ready=0 in MAC, WB, OUT.
REQ-018 err_len SHALL pulse the cycle after any accepted beat where in_last != (cnt==IN_SIZE-1); processing SHALL continue unchanged.
REQ-019 MAC, per group g: cycles i=0..IN_SIZE-1 assert w_rd with w_addr=g*IN_SIZE+i; cycle 0 also asserts b_rd with b_addr=g.
REQ-020 Accumulator lane l SHALL initialise to sign-extended bias << FRAC_BITS when bias data returns, then add buffer[i]*w_lane_l (full-precision signed product) one cycle after each read.
REQ-021 WB, one cycle per group: result = acc >>> FRAC_BITS (arithmetic, floor); if relu_en then negative -> 0; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; store into output buffer[g*LANES+l].
REQ-022 Each group SHALL take exactly IN_SIZE+2 cycles; after the last group go to OUT.
REQ-023 OUT: present neurons 0..NUM_NEURONS-1 in order; out_idx = neuron index; out_last=1 on index NUM_NEURONS-1; advance only when out_valid&&out_ready.
REQ-024 out_data/out_idx/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Last output accepted -> IDLE next cycle; in_ready=1 that cycle.
REQ-026 relu_en changes after the first beat SHALL NOT affect the current vector.
REQ-027 w_rd and b_rd SHALL be 0 outside MAC; out_valid SHALL be 0 outside OUT.

Reset
REQ-028 rst=1 at any time, including mid-LOAD/MAC/OUT: state=IDLE, counters=0, accumulators=0, out_valid=0, out_data=0, out_idx=0, out_last=0, w_rd=0, b_rd=0, busy=0, err_len=0, in_ready=0 while rst high, 1 the first cycle after release.
REQ-029 Partial vectors or results in progress at reset SHALL be discarded; no output beat is emitted for them.

Verification (IN_SIZE=4, NUM_NEURONS=4, LANES=2, DATA_W=16, FRAC_BITS=8)
REQ-030 x=256 x4, all weights 256, biases 0, relu_en=0 -> outputs idx0..3 = 1024, out_last on idx3, first out_valid exactly 4+2*(4+2) cycles after first accepted beat's cycle+1.
REQ-031 Weights -256, biases 0: relu_en=0 -> -1024 each; relu_en=1 -> 0 each.
REQ-032 x=32767, w=32767, bias=32767 -> 32767; w=-32768 with x=32767, bias=-32768 -> -32768.
REQ-033 out_ready low 3 cycles on idx1 -> out_data/out_idx held, no beat lost or duplicated, 4 beats total.
REQ-034 rst pulse during MAC group 1 -> busy=0, out_valid=0, in_ready=1 after release; new vector yields correct results.
REQ-035 in_last on beat 2 (cnt=1) -> err_len pulses once; beat 4 without in_last -> second pulse; outputs still computed.

Source files
------------

// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: buffers one activation vector, runs LANES-wide
// MAC groups against an external weight/bias memory, then streams the results out.
module fc_layer_seq #(
  parameter int IN_SIZE     = 784,
  parameter int NUM_NEURONS = 16,
  parameter int LANES       = 4,
  parameter int DATA_W      = 16,
  parameter int FRAC_BITS   = 8,
  localparam int ACC_W = 2*DATA_W + $clog2(IN_SIZE) + 1,
  localparam int NGRP  = NUM_NEURONS / LANES,
  localparam int WA_W  = ($clog2(NGRP*IN_SIZE) > 0) ? $clog2(NGRP*IN_SIZE) : 1,
  localparam int BA_W  = ($clog2(NGRP) > 0) ? $clog2(NGRP) : 1,
  localparam int IDX_W = ($clog2(NUM_NEURONS) > 0) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  input  logic                    relu_en,
  output logic                    w_rd,
  output logic [WA_W-1:0]         w_addr,
  input  logic [LANES*DATA_W-1:0] w_data,
  output logic                    b_rd,
  output logic [BA_W-1:0]         b_addr,
  input  logic [LANES*DATA_W-1:0] b_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err_len
);

  localparam int CNT_W = $clog2(IN_SIZE + 1);

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WB, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BA_W-1:0]   grp_q, grp_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              relu_q, relu_d;
  logic              err_q, err_d;

  logic signed [DATA_W-1:0] ibuf_q [IN_SIZE];
  logic signed [DATA_W-1:0] obuf_q [NUM_NEURONS];
  logic signed [ACC_W-1:0]  acc_q  [LANES];

  logic                       in_acc, last_beat;
  logic [CNT_W-1:0]           mac_idx;
  logic signed [DATA_W-1:0]   x_cur;
  logic signed [2*DATA_W-1:0] prod_w  [LANES];
  logic signed [ACC_W-1:0]    prod    [LANES];
  logic signed [ACC_W-1:0]    bias_sh [LANES];
  logic signed [ACC_W-1:0]    sh      [LANES];
  logic signed [DATA_W-1:0]   wb_res  [LANES];

  assign in_ready  = !rst && (state_q == S_IDLE || state_q == S_LOAD);
  assign in_acc    = in_valid && in_ready;
  assign last_beat = (cnt_q == CNT_W'(IN_SIZE - 1));
  assign busy      = (state_q != S_IDLE);
  assign err_len   = err_q;

  assign w_rd   = (state_q == S_MAC) && (cnt_q < CNT_W'(IN_SIZE));
  assign b_rd   = (state_q == S_MAC) && (cnt_q == '0);
  assign w_addr = WA_W'(int'(grp_q) * IN_SIZE + int'(cnt_q));
  assign b_addr = grp_q;

  assign out_valid = (state_q == S_OUT);
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == IDX_W'(NUM_NEURONS - 1));
  assign out_data  = out_valid ? obuf_q[idx_q] : '0;

  // Read data for MAC index cnt-1 arrives while cnt is current.
  assign mac_idx = cnt_q - CNT_W'(1);
  assign x_cur   = ibuf_q[mac_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    idx_d   = idx_q;
    relu_d  = relu_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_acc) begin
          if (cnt_q == '0) relu_d = relu_en;
          err_d = (in_last != last_beat);
          if (last_beat) begin
            state_d = S_MAC;
            cnt_d   = '0;
            grp_d   = '0;
          end else begin
            state_d = S_LOAD;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      S_MAC: begin
        if (cnt_q == CNT_W'(IN_SIZE)) state_d = S_WB;
        else                          cnt_d   = cnt_q + CNT_W'(1);
      end
      S_WB: begin
        cnt_d = '0;
        if (grp_q == BA_W'(NGRP - 1)) begin
          state_d = S_OUT;
          idx_d   = '0;
        end else begin
          state_d = S_MAC;
          grp_d   = grp_q + BA_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      prod_w[l]  = (2*DATA_W)'(x_cur) * (2*DATA_W)'($signed(w_data[l*DATA_W +: DATA_W]));
      prod[l]    = ACC_W'(prod_w[l]);
      bias_sh[l] = ACC_W'($signed(b_data[l*DATA_W +: DATA_W])) <<< FRAC_BITS;
      sh[l]      = acc_q[l] >>> FRAC_BITS;
      if (relu_q && sh[l] < 0) sh[l] = '0;
      if (sh[l] > MAXV)      wb_res[l] = MAXV[DATA_W-1:0];
      else if (sh[l] < MINV) wb_res[l] = MINV[DATA_W-1:0];
      else                   wb_res[l] = sh[l][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      grp_q   <= '0;
      idx_q   <= '0;
      relu_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      idx_q   <= idx_d;
      relu_q  <= relu_d;
      err_q   <= err_d;
    end
  end

  // The first returning beat of a group seeds the accumulator with the bias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else if (state_q == S_MAC && cnt_q != '0) begin
      for (int unsigned l = 0; l < LANES; l++)
        acc_q[l] <= ((cnt_q == CNT_W'(1)) ? bias_sh[l] : acc_q[l]) + prod[l];
    end
  end

  always_ff @(posedge clk) begin
    if (in_acc) ibuf_q[cnt_q] <= in_data;
    if (state_q == S_WB) begin
      for (int unsigned n = 0; n < NUM_NEURONS; n++)
        if (grp_q == BA_W'(n / LANES)) obuf_q[n] <= wb_res[n % LANES];
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Randomized bench for fc_layer_seq against an arithmetic reference of the layer.
module tb_fc_layer_seq;

  localparam int IN_SIZE = 4;
  localparam int NN      = 4;
  localparam int LANES   = 2;
  localparam int DW      = 16;
  localparam int FB      = 8;
  localparam int NG      = NN / LANES;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_ready, in_last, relu_en;
  logic [DW-1:0]         in_data;
  logic                  w_rd, b_rd;
  logic [2:0]            w_addr;
  logic [0:0]            b_addr;
  logic [LANES*DW-1:0]   w_data, b_data;
  logic                  out_valid, out_ready, out_last, busy, err_len;
  logic [DW-1:0]         out_data;
  logic [1:0]            out_idx;

  fc_layer_seq #(.IN_SIZE(IN_SIZE), .NUM_NEURONS(NN), .LANES(LANES), .DATA_W(DW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .relu_en(relu_en),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .b_rd(b_rd), .b_addr(b_addr), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_bad = 0;
  int unsigned cyc = 0;
  int          err_cnt = 0, proto_bad = 0;
  int          xv [IN_SIZE];
  int          wv [NN][IN_SIZE];
  int          bv [NN];
  logic [LANES*DW-1:0] wmem [NG*IN_SIZE];
  logic [LANES*DW-1:0] bmem [NG];

  // One-cycle read memories; junk on the bus whenever no read was issued.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    w_data <= w_rd ? wmem[w_addr] : LANES*DW'($urandom);
    b_data <= b_rd ? bmem[b_addr] : LANES*DW'($urandom);
  end

  always @(negedge clk) begin
    if (err_len) err_cnt++;
    if ((w_rd || b_rd) && (out_valid || !busy)) proto_bad++;
    if (out_valid && in_ready) proto_bad++;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rs16();
    logic [15:0] v;
    v = 16'($urandom);
    return int'($signed(v));
  endfunction

  task automatic rand_data(input bit full);
    for (int n = 0; n < NN; n++) begin
      bv[n] = full ? rs16() : $urandom_range(0, 4000) - 2000;
      for (int i = 0; i < IN_SIZE; i++) wv[n][i] = full ? rs16() : $urandom_range(0, 1023) - 512;
    end
    for (int i = 0; i < IN_SIZE; i++) xv[i] = full ? rs16() : $urandom_range(0, 1023) - 512;
  endtask

  task automatic fill(input int x, input int w, input int b);
    for (int n = 0; n < NN; n++) begin
      bv[n] = b;
      for (int i = 0; i < IN_SIZE; i++) wv[n][i] = w;
    end
    for (int i = 0; i < IN_SIZE; i++) xv[i] = x;
  endtask

  task automatic load_mem();
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < IN_SIZE; i++) wmem[(n/LANES)*IN_SIZE + i][(n%LANES)*DW +: DW] = DW'(wv[n][i]);
      bmem[n/LANES][(n%LANES)*DW +: DW] = DW'(bv[n]);
    end
  endtask

  // Neuron n = floor((bias*2^FB + sum x*w) / 2^FB), optional ReLU, clamp to DW bits.
  function automatic longint model(input int n, input bit relu);
    longint s, d, r;
    d = longint'(1) << FB;
    s = longint'(bv[n]) * d;
    for (int i = 0; i < IN_SIZE; i++) s += longint'(xv[i]) * longint'(wv[n][i]);
    r = s / d;
    if ((s % d) != 0 && s < 0) r = r - 1;
    if (relu && r < 0) r = 0;
    if (r > (longint'(1) << (DW-1)) - 1) r = (longint'(1) << (DW-1)) - 1;
    if (r < -(longint'(1) << (DW-1)))    r = -(longint'(1) << (DW-1));
    return r;
  endfunction

  task automatic send(input bit relu, input bit [IN_SIZE-1:0] lastv, input bit gaps, output int unsigned t0);
    t0 = 0;
    for (int k = 0; k < IN_SIZE; k++) begin
      if (gaps && k > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = DW'(xv[k]);
      in_last  = lastv[k];
      relu_en  = (k == 0) ? relu : 1'($urandom_range(0, 1));
      check("in_ready_load", in_ready, 1);
      @(negedge clk);
      if (k == 0) t0 = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    relu_en  = ~relu;
  endtask

  task automatic collect(input int mode, input longint e [NN], input int unsigned t0, input bit chk_lat);
    int k = 0, tmo = 0, stall = 0;
    bit first = 1, holding = 0;
    logic [DW-1:0] hd;
    logic [1:0]    hi;
    while (k < NN && tmo < 300) begin
      case (mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = !(out_valid && out_idx == 2'd1 && stall < 3);
        default: out_ready = 1'b1;
      endcase
      if (out_valid) begin
        if (first && chk_lat) check("first_valid_latency", int'(cyc + 1 - t0), 4 + 2*(IN_SIZE + 2));
        first = 0;
        if (holding) begin
          check("hold_data", out_data, hd);
          check("hold_idx", out_idx, hi);
        end
        if (out_ready) begin
          check("out_idx", out_idx, k);
          check("out_data", longint'($signed(out_data)), e[k]);
          check("out_last", out_last, (k == NN-1) ? 1 : 0);
          k++;
          holding = 0;
        end else begin
          holding = 1;
          hd = out_data;
          hi = out_idx;
          if (mode == 2) stall++;
        end
      end
      @(negedge clk);
      tmo++;
    end
    out_ready = 1'b0;
    check("beats", k, NN);
    if (mode == 2) check("stall_cycles", stall, 3);
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  task automatic run_case(input bit relu, input bit [IN_SIZE-1:0] lastv, input bit gaps,
                          input int mode, input bit chk_lat);
    longint      e [NN];
    int          e0, nerr;
    int unsigned t0;
    load_mem();
    for (int n = 0; n < NN; n++) e[n] = model(n, relu);
    nerr = 0;
    for (int k = 0; k < IN_SIZE; k++) if (lastv[k] != (k == IN_SIZE-1)) nerr++;
    e0 = err_cnt;
    send(relu, lastv, gaps, t0);
    collect(mode, e, t0, chk_lat);
    check("err_len_pulses", err_cnt - e0, nerr);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_w_rd", w_rd, 0);
    check("rst_b_rd", b_rd, 0);
    check("rst_err_len", err_len, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
  endtask

  localparam bit [IN_SIZE-1:0] STD_LAST = 1 << (IN_SIZE-1);

  initial begin
    int unsigned t0;
    int seen, tmo;
    bit [IN_SIZE-1:0] lv;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    #1 check("in_ready_release", in_ready, 1);
    @(negedge clk);

    fill(256, 256, 0);
    run_case(1'b0, STD_LAST, 1'b0, 0, 1'b1);
    fill(256, -256, 0);
    run_case(1'b0, STD_LAST, 1'b0, 0, 1'b0);
    run_case(1'b1, STD_LAST, 1'b1, 0, 1'b0);
    fill(32767, 32767, 32767);
    run_case(1'b0, STD_LAST, 1'b0, 1, 1'b0);
    fill(32767, -32768, -32768);
    run_case(1'b0, STD_LAST, 1'b0, 1, 1'b0);

    rand_data(1'b0);
    run_case(1'b0, STD_LAST, 1'b0, 2, 1'b0);

    rand_data(1'b0);
    run_case(1'b1, 4'b0010, 1'b0, 0, 1'b0);

    // Reset while group 1 is accumulating; nothing from that vector may come out.
    rand_data(1'b0);
    load_mem();
    send(1'b0, STD_LAST, 1'b0, t0);
    tmo = 0;
    while (!(b_rd && b_addr == 1'b1) && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    check("reached_group1", (b_rd && b_addr == 1'b1) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready_after_mid_rst", in_ready, 1);
    check("busy_after_mid_rst", busy, 0);
    out_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("no_beats_after_rst", seen, 0);
    rand_data(1'b1);
    run_case(1'b0, STD_LAST, 1'b1, 1, 1'b0);

    for (int it = 0; it < 20; it++) begin
      rand_data(1'($urandom_range(0, 1)));
      lv = ($urandom_range(0, 3) == 0) ? IN_SIZE'($urandom) : STD_LAST;
      run_case(1'($urandom_range(0, 1)), lv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b0);
    end

    check("protocol_violations", proto_bad, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

endmodule
